// File: rtl/xbtn_entry.sv
// Button front end for the 7-segment decoder: debounce, entry FSM,
// display write strobe and valid/ready hand-off of the confirmed number.
`timescale 1ns/1ps
module xbtn_entry #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int MAX_VAL     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [7:0] disp_bin,
  output logic       disp_sgn,
  output logic [1:0] disp_msg,
  output logic       disp_wr,
  output logic       disp_sel,
  output logic [7:0] out_value,
  output logic       out_sgn,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_OP, S_EDIT, S_VAL, S_ERR
  } state_t;

  logic [3:0]    r_s1, r_s2, r_stb, r_evt;
  logic [DW-1:0] r_cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_stb <= '0;
      r_evt <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1  <= btn;
      r_s2  <= r_s1;
      r_evt <= '0;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_stb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_stb[i] <= r_s2[i];
          r_evt[i] <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Single event per cycle: enter > inc > dec > sign.
  logic [3:0] w_take;
  always_comb begin
    w_take = '0;
    if (r_evt[3])      w_take[3] = 1'b1;
    else if (r_evt[0]) w_take[0] = 1'b1;
    else if (r_evt[1]) w_take[1] = 1'b1;
    else if (r_evt[2]) w_take[2] = 1'b1;
  end

  state_t        r_st;
  logic [7:0]    r_val;
  logic          r_sgn;
  logic [HW-1:0] r_tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= S_OP;
      r_val     <= '0;
      r_sgn     <= 1'b0;
      r_tmr     <= '0;
      out_value <= '0;
      out_sgn   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (r_st)
        S_OP: if (|w_take) r_st <= S_EDIT;
        S_EDIT: begin
          unique case (1'b1)
            w_take[3]: begin
              out_value <= r_val;
              out_sgn   <= r_sgn;
              out_valid <= 1'b1;
              r_st      <= S_VAL;
            end
            w_take[0]: begin
              if (r_val < 8'(MAX_VAL)) begin
                r_val <= r_val + 1'b1;
              end else begin
                r_st  <= S_ERR;
                r_tmr <= '0;
              end
            end
            w_take[1]: begin
              if (r_val != 8'd0) begin
                r_val <= r_val - 1'b1;
                if (r_val == 8'd1) r_sgn <= 1'b0;
              end else begin
                r_st  <= S_ERR;
                r_tmr <= '0;
              end
            end
            w_take[2]: if (r_val != 8'd0) r_sgn <= ~r_sgn;
            default: ;
          endcase
        end
        S_VAL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_val     <= '0;
            r_sgn     <= 1'b0;
            r_st      <= S_OP;
          end
        end
        S_ERR: begin
          if (r_tmr == HW'(HOLD_CYCLES - 1)) r_st <= S_EDIT;
          else r_tmr <= r_tmr + 1'b1;
        end
        default: r_st <= S_OP;
      endcase
    end
  end

  logic [1:0] w_msg;
  always_comb begin
    w_msg = 2'b01;
    unique case (r_st)
      S_OP:    w_msg = 2'b01;
      S_EDIT:  w_msg = 2'b00;
      S_VAL:   w_msg = 2'b10;
      S_ERR:   w_msg = 2'b11;
      default: w_msg = 2'b01;
    endcase
  end

  // Strobe rides with the newly loaded display word; r_first forces one after reset.
  logic r_first;
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bin <= '0;
      disp_sgn <= 1'b0;
      disp_msg <= 2'b01;
      disp_wr  <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      disp_bin <= r_val;
      disp_sgn <= r_sgn;
      disp_msg <= w_msg;
      r_first  <= 1'b0;
      disp_wr  <= r_first |
                  ({r_val, r_sgn, w_msg} != {disp_bin, disp_sgn, disp_msg});
    end
  end

  assign disp_sel = disp_wr;

endmodule
